// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instr_prefetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } pf_state_t;

  localparam logic [15:0] HALFWORD_INC     = 16'd2;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Prefetch FIFO holding fetched instruction words with their addresses.
// Flush empties the queue; push on a full queue is accepted only alongside a pop.
module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: credit-limited fetch stream into a FIFO, with redirect flush.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to the core when the FIFO is empty.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  pf_state_t     state, state_nxt;
  logic [15:0]   fpc;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] drop_cnt, drop_cnt_nxt;
  logic [15:0]   tag_mem [DEPTH];
  logic [PW-1:0] tag_wr, tag_rd;
  logic          gnt_fire, rsp_accept, rsp_drop, rsp_keep, bypass;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  logic [CW:0]   occ, occ_nxt;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  // Credits: every FIFO slot is either filled or reserved by an in-flight request.
  assign occ        = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req    = ~reset & (state == FETCH) & ~fifo_full & (occ < (CW+1)'(DEPTH));
  assign mem_addr   = fpc;
  assign gnt_fire   = mem_req & mem_gnt;
  assign rsp_accept = mem_rvalid & (outstanding != '0);
  assign rsp_drop   = rsp_accept & ((state == FLUSH) | redirect_valid);
  assign rsp_keep   = rsp_accept & ~rsp_drop;

  assign outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(rsp_accept);

`ifdef PREFETCH_BYPASS_EN
  assign bypass = rsp_keep & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_pop    = instr_ready & ~fifo_empty;
  assign fifo_push   = rsp_keep & ~(bypass & instr_ready);
  assign instr_valid = ~fifo_empty | bypass;
  assign instr       = ~fifo_empty ? fifo_head.data : (bypass ? mem_rdata : 16'h0000);
  assign instr_pc    = ~fifo_empty ? fifo_head.pc : (bypass ? tag_mem[tag_rd] : 16'h0000);

  assign occ_nxt = {1'b0, fifo_count} + (CW+1)'(fifo_push) - (CW+1)'(fifo_pop)
                   + {1'b0, outstanding_nxt};

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry ('{pc: tag_mem[tag_rd], data: mem_rdata}),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  // A redirect drops everything still in flight, including a grant taken this cycle.
  always_comb begin
    state_nxt    = state;
    drop_cnt_nxt = drop_cnt;
    if (redirect_valid) begin
      drop_cnt_nxt = outstanding_nxt;
      state_nxt    = (outstanding_nxt != '0) ? FLUSH : FETCH;
    end else begin
      case (state)
        FLUSH: begin
          if (rsp_accept) drop_cnt_nxt = drop_cnt - CW'(1);
          if (drop_cnt_nxt == '0) state_nxt = FETCH;
        end
        default: state_nxt = (occ_nxt >= (CW+1)'(DEPTH)) ? FULL : FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      fpc         <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      state       <= state_nxt;
      drop_cnt    <= drop_cnt_nxt;
      outstanding <= outstanding_nxt;
      if (redirect_valid) fpc <= {redirect_pc[15:1], 1'b0};
      else if (gnt_fire)  fpc <= fpc + HALFWORD_INC;
      if (gnt_fire)   tag_wr <= tag_wr + 1'b1;
      if (rsp_accept) tag_rd <= tag_rd + 1'b1;
    end
  end

  // Issue-order address tags; responses return in order so the oldest tag names each response.
  always_ff @(posedge clk) begin
    if (gnt_fire) tag_mem[tag_wr] <= fpc;
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: queue-based reference model compared every cycle plus directed literal checks.
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  logic        clk, reset, redirect_valid, mem_req, mem_gnt, mem_rvalid;
  logic        instr_valid, instr_ready;
  logic [15:0] redirect_pc, mem_addr, mem_rdata, instr, instr_pc;

  int total = 0;
  int bad   = 0;

  logic        rsp_en;
  logic [15:0] mem_q[$];
  logic [15:0] m_outq[$];
  ent_t        m_fifo[$];
  int          m_drop;
  logic [15:0] m_fpc;
  logic [15:0] grant_log[$];
  ent_t        cons_log[$];

  logic        exp_req, exp_v, m_rsp, m_byp;
  logic [15:0] exp_i, exp_pc, m_a;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: accepts grants, returns data = addr ^ A5A5 one cycle later, in order.
  always @(negedge clk) begin
    if (reset) mem_q.delete();
    else if (mem_req && mem_gnt) mem_q.push_back(mem_addr);
  end

  always @(posedge clk) begin
    #2;
    if (reset || !rsp_en || mem_q.size() == 0) begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
    end else begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_q.pop_front() ^ 16'hA5A5;
    end
  end

  // Reference model: FIFO contents, in-flight addresses, and a count of responses to discard.
  always @(negedge clk) begin
    if (reset) begin
      m_fifo.delete();
      m_outq.delete();
      m_drop = 0;
      m_fpc  = 16'h0000;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_instr_pc", instr_pc, 16'h0000);
    end else begin
      if (mem_rvalid && m_outq.size() == 0) chk("proto_rvalid_no_outstanding", 1, 0);
      m_rsp   = mem_rvalid && (m_outq.size() > 0);
      exp_req = (m_drop == 0) && (m_fifo.size() + m_outq.size() < DEPTH);
      m_byp   = 1'b0;
`ifdef PREFETCH_BYPASS_EN
      m_byp = m_rsp && (m_drop == 0) && !redirect_valid && (m_fifo.size() == 0);
`endif
      exp_v  = (m_fifo.size() > 0) || m_byp;
      exp_i  = (m_fifo.size() > 0) ? m_fifo[0].data : mem_rdata;
      exp_pc = (m_fifo.size() > 0) ? m_fifo[0].pc : ((m_outq.size() > 0) ? m_outq[0] : 16'h0000);
      chk("mem_req", mem_req, exp_req);
      chk("mem_addr", mem_addr, m_fpc);
      chk("instr_valid", instr_valid, exp_v);
      if (exp_v) begin
        chk("instr", instr, exp_i);
        chk("instr_pc", instr_pc, exp_pc);
      end
      if (exp_v && instr_ready) begin
        cons_log.push_back({exp_pc, exp_i});
        if (!m_byp) void'(m_fifo.pop_front());
      end
      if (m_rsp) begin
        m_a = m_outq.pop_front();
        if (m_drop > 0) m_drop--;
        else if (!redirect_valid && !(m_byp && instr_ready)) m_fifo.push_back({m_a, mem_rdata});
      end
      if (exp_req && mem_gnt) begin
        grant_log.push_back(m_fpc);
        m_outq.push_back(m_fpc);
        m_fpc = m_fpc + 16'd2;
      end
      if (redirect_valid) begin
        m_fifo.delete();
        m_drop = m_outq.size();
        m_fpc  = redirect_pc & 16'hFFFE;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    grant_log.delete();
    cons_log.delete();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] cpc(input int i);
    return (i < cons_log.size()) ? cons_log[i].pc : 16'hDEAD;
  endfunction

  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = 0; mem_gnt = 1; instr_ready = 1; rsp_en = 1;
    mem_rvalid = 0; mem_rdata = 0;
    cyc(3);

    // Streaming from reset, first response A5A5 at address 0000
    grant_log.delete(); cons_log.delete();
    reset = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("lat_rvalid_c1", mem_rvalid, 1);
`ifdef PREFETCH_BYPASS_EN
    chk("lat_bypass_valid", instr_valid, 1);
    chk("lat_bypass_instr", instr, 16'hA5A5);
`else
    chk("lat_nobypass_valid", instr_valid, 0);
    @(negedge clk); #1;
    chk("lat_fifo_valid", instr_valid, 1);
    chk("lat_fifo_instr", instr, 16'hA5A5);
    chk("lat_fifo_pc", instr_pc, 16'h0000);
`endif
    @(posedge clk); #1;
`ifdef PREFETCH_BYPASS_EN
    cyc(8);
    chk("steady_count", cons_log.size(), 9);
`else
    cyc(7);
    chk("steady_count", cons_log.size(), 8);
`endif
    chk("stream_g0", glog(0), 16'h0000);
    chk("stream_g1", glog(1), 16'h0002);
    chk("stream_g2", glog(2), 16'h0004);
    chk("stream_g3", glog(3), 16'h0006);
    chk("stream_pc2", cpc(2), 16'h0004);

    // Credit exhaustion with a stalled core
    instr_ready = 0;
    do_reset();
    cyc(8);
    chk("full_grants", grant_log.size(), 4);
    chk("full_no_req", mem_req, 0);
    instr_ready = 1;
    cyc(1);
    instr_ready = 0;
    cyc(4);
    chk("full_refill_grants", grant_log.size(), 5);
    chk("full_refill_addr", glog(4), 16'h0008);
    chk("full_pop_pc", cpc(0), 16'h0000);

    // Redirect to odd address with three requests in flight
    instr_ready = 1; rsp_en = 0;
    do_reset();
    cyc(3);
    mem_gnt = 0; redirect_valid = 1; redirect_pc = 16'h0041;
    cyc(1);
    redirect_valid = 0; mem_gnt = 1; rsp_en = 1;
    grant_log.delete(); cons_log.delete();
    cyc(1);
    chk("flush_no_req", mem_req, 0);
    cyc(8);
    chk("redir_first_grant", glog(0), 16'h0040);
    chk("redir_first_pc", cpc(0), 16'h0040);
    chk("redir_first_data", (cons_log.size() > 0) ? cons_log[0].data : 16'hDEAD, 16'hA5E5);

    // Address wrap at the top of memory
    mem_gnt = 0;
    do_reset();
    redirect_valid = 1; redirect_pc = 16'hFFFC;
    cyc(1);
    redirect_valid = 0; mem_gnt = 1;
    grant_log.delete(); cons_log.delete();
    cyc(6);
    chk("wrap_g0", glog(0), 16'hFFFC);
    chk("wrap_g1", glog(1), 16'hFFFE);
    chk("wrap_g2", glog(2), 16'h0000);
    chk("wrap_pc1", cpc(1), 16'hFFFE);
    chk("wrap_pc2", cpc(2), 16'h0000);

    // Redirect coinciding with a pop and a response
    do_reset();
    cyc(5);
    redirect_valid = 1; redirect_pc = 16'h0200;
    cyc(1);
    redirect_valid = 0;
    chk("coinc_cons_count", cons_log.size(), 4);
    chk("coinc_last_pc", cpc(3), 16'h0006);
    chk("coinc_last_data", (cons_log.size() > 3) ? cons_log[3].data : 16'hDEAD, 16'hA5A3);
    @(negedge clk); #1;
    chk("coinc_empty_after", instr_valid, 0);
    grant_log.delete(); cons_log.delete();
    @(posedge clk); #1;
    cyc(5);
    chk("coinc_new_pc", cpc(0), 16'h0200);

    // Reset in the middle of a stream
    reset = 1;
    cyc(2);
    reset = 0;
    cyc(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
